// File: rtl/video_out_stage.sv
// Video output conditioner: blank/sync normalisation, colour expansion,
// debug patterns, scanline dimming and an equal-latency output pipeline.
module video_out_stage #(
    parameter int IN_BITS      = 4,
    parameter int OUT_BITS     = 8,
    parameter int BLANK_IN_LOW = 1,
    parameter int HSYNC_INV    = 0,
    parameter int VSYNC_INV    = 1,
    parameter int LATENCY      = 2,
    parameter int BAR_SHIFT    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_pix_in,
    input  logic [IN_BITS-1:0]    r_in,
    input  logic [IN_BITS-1:0]    g_in,
    input  logic [IN_BITS-1:0]    b_in,
    input  logic                  hblank_in,
    input  logic                  vblank_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  csync_in,
    input  logic [1:0]            mode,
    input  logic [3*OUT_BITS-1:0] dbg_color,
    input  logic                  scanline_en,
    input  logic [1:0]            scanline_lvl,
    output logic [OUT_BITS-1:0]   r_out,
    output logic [OUT_BITS-1:0]   g_out,
    output logic [OUT_BITS-1:0]   b_out,
    output logic                  hblank_out,
    output logic                  vblank_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  csync_out,
    output logic                  de_out,
    output logic                  ce_pix_out,
    output logic [1:0]            mode_active
);

    typedef struct packed {
        logic [OUT_BITS-1:0] r;
        logic [OUT_BITS-1:0] g;
        logic [OUT_BITS-1:0] b;
        logic                hb;
        logic                vb;
        logic                hs;
        logic                vs;
        logic                cs;
        logic                de;
        logic                ce;
    } px_t;

    localparam px_t RST_PX = px_t'({{(3*OUT_BITS){1'b0}}, 7'b1100000});
    localparam logic BL_X = (BLANK_IN_LOW != 0);
    localparam logic HS_X = (HSYNC_INV != 0);
    localparam logic VS_X = (VSYNC_INV != 0);

    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        logic [OUT_BITS-1:0] o;
        o = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            o[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
        end
        return o;
    endfunction

    function automatic logic [OUT_BITS-1:0] dim(input logic [OUT_BITS-1:0] c,
                                                input logic [1:0] lvl);
        logic [OUT_BITS-1:0] d;
        d = '0;
        unique case (lvl)
            2'd0: d = c - (c >> 2);
            2'd1: d = c >> 1;
            2'd2: d = c >> 2;
            2'd3: d = '0;
        endcase
        return d;
    endfunction

    logic                hb, vb, de;
    logic [11:0]         x_q, x_d, y_q, y_d;
    logic                de_seen_q, vb_prev_q;
    logic [1:0]          mode_q;
    logic [2:0]          bar_idx;
    logic                grid_on;
    logic [OUT_BITS-1:0] pr, pg, pb;
    px_t                 s1_d, s1_q, s2_d, s2_q, po;
    logic                y0_q;

    always_comb begin
        hb = hblank_in ^ BL_X;
        vb = vblank_in ^ BL_X;
        de = ~hb & ~vb;
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (ce_pix_in) begin
            if (hb) x_d = '0;
            else if (de) x_d = x_q + 12'd1;
            if (vb) y_d = '0;
            else if (hb && de_seen_q) y_d = y_q + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            de_seen_q <= 1'b0;
            vb_prev_q <= 1'b0;
            mode_q    <= 2'd0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vb_prev_q <= vb;
            if (ce_pix_in) de_seen_q <= de;
            // Mode only changes at vblank start to avoid mid-frame tearing
            if (vb && !vb_prev_q) mode_q <= mode;
        end
    end

    always_comb begin
        bar_idx = x_q[BAR_SHIFT+2 -: 3];
        grid_on = (x_q[3:0] == 4'd0) || (y_q[3:0] == 4'd0);
        pr = expand(r_in);
        pg = expand(g_in);
        pb = expand(b_in);
        unique case (mode_q)
            2'd0: ;
            2'd1: begin
                pr = {OUT_BITS{bar_idx[1]}};
                pg = {OUT_BITS{bar_idx[2]}};
                pb = {OUT_BITS{bar_idx[0]}};
            end
            2'd2: begin
                pr = {OUT_BITS{grid_on}};
                pg = {OUT_BITS{grid_on}};
                pb = {OUT_BITS{grid_on}};
            end
            2'd3: {pr, pg, pb} = dbg_color;
        endcase
    end

    always_comb begin
        s1_d    = RST_PX;
        s1_d.r  = pr;
        s1_d.g  = pg;
        s1_d.b  = pb;
        s1_d.hb = hb;
        s1_d.vb = vb;
        s1_d.hs = hsync_in ^ HS_X;
        s1_d.vs = vsync_in ^ VS_X;
        s1_d.cs = csync_in;
        s1_d.de = de;
        s1_d.ce = ce_pix_in;
    end

    always_comb begin
        s2_d = s1_q;
        if (scanline_en && y0_q) begin
            s2_d.r = dim(s1_q.r, scanline_lvl);
            s2_d.g = dim(s1_q.g, scanline_lvl);
            s2_d.b = dim(s1_q.b, scanline_lvl);
        end
        s2_d.r = s2_d.r & {OUT_BITS{s1_q.de}};
        s2_d.g = s2_d.g & {OUT_BITS{s1_q.de}};
        s2_d.b = s2_d.b & {OUT_BITS{s1_q.de}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= RST_PX;
            y0_q <= 1'b0;
            s2_q <= RST_PX;
        end else begin
            s1_q <= s1_d;
            y0_q <= y_q[0];
            s2_q <= s2_d;
        end
    end

    if (LATENCY > 2) begin : g_dly
        px_t dly_q [LATENCY-2];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LATENCY-2; i++) dly_q[i] <= RST_PX;
            end else begin
                dly_q[0] <= s2_q;
                for (int i = 1; i < LATENCY-2; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign po = dly_q[LATENCY-3];
    end else begin : g_nodly
        assign po = s2_q;
    end

    assign r_out       = po.r;
    assign g_out       = po.g;
    assign b_out       = po.b;
    assign hblank_out  = po.hb;
    assign vblank_out  = po.vb;
    assign hsync_out   = po.hs;
    assign vsync_out   = po.vs;
    assign csync_out   = po.cs;
    assign de_out      = po.de;
    assign ce_pix_out  = po.ce;
    assign mode_active = mode_q;

endmodule

// File: tb/tb_video_out_stage.sv
// Bench for video_out_stage: frame-level reference model compared every
// cycle against a LATENCY=2 and a LATENCY=5 instance, plus literal pins.
`timescale 1ns/1ps
module tb_video_out_stage;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic hb, vb, hs, vs, cs, de, ce;
    } out_t;

    localparam out_t RSTV = out_t'({24'h0, 7'b1100000});

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ce_i = 1'b0;
    logic [3:0] r_i = '0, g_i = '0, b_i = '0;
    logic       hbl_i = 1'b1, vbl_i = 1'b1;
    logic       hs_i = 1'b0, vs_i = 1'b1, cs_i = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic [23:0] dbg_i = '0;
    logic       sc_en = 1'b0;
    logic [1:0] sc_lvl = 2'd0;

    logic [7:0] o2_r, o2_g, o2_b, o5_r, o5_g, o5_b;
    logic o2_hb, o2_vb, o2_hs, o2_vs, o2_cs, o2_de, o2_ce;
    logic o5_hb, o5_vb, o5_hs, o5_vs, o5_cs, o5_de, o5_ce;
    logic [1:0] o2_m, o5_m;

    video_out_stage #(.LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst), .ce_pix_in(ce_i),
        .r_in(r_i), .g_in(g_i), .b_in(b_i),
        .hblank_in(hbl_i), .vblank_in(vbl_i),
        .hsync_in(hs_i), .vsync_in(vs_i), .csync_in(cs_i),
        .mode(mode_i), .dbg_color(dbg_i),
        .scanline_en(sc_en), .scanline_lvl(sc_lvl),
        .r_out(o2_r), .g_out(o2_g), .b_out(o2_b),
        .hblank_out(o2_hb), .vblank_out(o2_vb),
        .hsync_out(o2_hs), .vsync_out(o2_vs), .csync_out(o2_cs),
        .de_out(o2_de), .ce_pix_out(o2_ce), .mode_active(o2_m)
    );

    video_out_stage #(.LATENCY(5)) u_dut5 (
        .clk(clk), .reset(rst), .ce_pix_in(ce_i),
        .r_in(r_i), .g_in(g_i), .b_in(b_i),
        .hblank_in(hbl_i), .vblank_in(vbl_i),
        .hsync_in(hs_i), .vsync_in(vs_i), .csync_in(cs_i),
        .mode(mode_i), .dbg_color(dbg_i),
        .scanline_en(sc_en), .scanline_lvl(sc_lvl),
        .r_out(o5_r), .g_out(o5_g), .b_out(o5_b),
        .hblank_out(o5_hb), .vblank_out(o5_vb),
        .hsync_out(o5_hs), .vsync_out(o5_vs), .csync_out(o5_cs),
        .de_out(o5_de), .ce_pix_out(o5_ce), .mode_active(o5_m)
    );

    out_t        hist[$];
    int          last_rst = -1;
    logic [1:0]  m_mode = 2'd0;
    logic        prev_vb = 1'b0;
    int          n_chk = 0, n_pass = 0, n_fail = 0;
    logic [23:0] got2[int];
    int          base[32];

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic out_t snap2();
        return out_t'({o2_r, o2_g, o2_b, o2_hb, o2_vb, o2_hs, o2_vs,
                       o2_cs, o2_de, o2_ce});
    endfunction

    function automatic out_t snap5();
        return out_t'({o5_r, o5_g, o5_b, o5_hb, o5_vb, o5_hs, o5_vs,
                       o5_cs, o5_de, o5_ce});
    endfunction

    function automatic int dimv(input int c);
        if (!sc_en) return c;
        case (sc_lvl)
            2'd0: return c - c / 4;
            2'd1: return c / 2;
            2'd2: return c / 4;
            default: return 0;
        endcase
    endfunction

    // Expected output for the pixel currently on the inputs at (col, line)
    task automatic push(input int col, input int line);
        out_t e;
        int cr, cg, cb, idx;
        logic hb, vb, de;
        if (rst) begin
            last_rst = hist.size();
            hist.push_back(RSTV);
            m_mode = 2'd0;
            prev_vb = 1'b0;
            return;
        end
        hb = !hbl_i;
        vb = !vbl_i;
        de = !hb && !vb;
        cr = 0; cg = 0; cb = 0;
        case (m_mode)
            2'd0: begin cr = r_i * 17; cg = g_i * 17; cb = b_i * 17; end
            2'd1: begin
                idx = (col / 32) % 8;
                cr = ((idx / 2) % 2) ? 255 : 0;
                cg = ((idx / 4) % 2) ? 255 : 0;
                cb = (idx % 2) ? 255 : 0;
            end
            2'd2: begin
                cr = (col % 16 == 0 || line % 16 == 0) ? 255 : 0;
                cg = cr; cb = cr;
            end
            default: begin cr = dbg_i[23:16]; cg = dbg_i[15:8]; cb = dbg_i[7:0]; end
        endcase
        if (line % 2 == 1) begin cr = dimv(cr); cg = dimv(cg); cb = dimv(cb); end
        if (!de) begin cr = 0; cg = 0; cb = 0; end
        e.r = 8'(cr); e.g = 8'(cg); e.b = 8'(cb);
        e.hb = hb; e.vb = vb; e.de = de;
        e.hs = hs_i; e.vs = !vs_i; e.cs = cs_i; e.ce = ce_i;
        hist.push_back(e);
        if (vb && !prev_vb) m_mode = mode_i;
        prev_vb = vb;
    endtask

    function automatic out_t exp_at(input int i);
        if (rst || i < 0 || i <= last_rst) return RSTV;
        return hist[i];
    endfunction

    always @(negedge clk) begin
        check("pipe_lat2", 32'(snap2()), 32'(exp_at(hist.size() - 2)));
        check("pipe_lat5", 32'(snap5()), 32'(exp_at(hist.size() - 5)));
        check("mode_active", {28'd0, o2_m, o5_m}, {28'd0, m_mode, m_mode});
        if (hist.size() >= 2) got2[hist.size() - 2] = {o2_r, o2_g, o2_b};
    end

    task automatic step(input int col, input int line);
        push(col, line);
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input int nl, input bit flat, input int cl,
                         input int cp, input logic [1:0] nm,
                         output logic [1:0] ma_vb);
        ma_vb = 2'd0;
        for (int l = -2; l < nl; l++) begin
            for (int p = 0; p < 264; p++) begin
                vbl_i = (l >= 0);
                hbl_i = (p < 256);
                hs_i  = !(p >= 258 && p < 262);
                vs_i  = (l != -1);
                cs_i  = hs_i & vs_i;
                ce_i  = 1'b1;
                if (flat) begin
                    r_i = 4'hF; g_i = 4'hF; b_i = 4'hF;
                end else begin
                    r_i = 4'(p);
                    g_i = 4'(p / 16 + l);
                    b_i = ~4'(p);
                end
                if (l == cl && p == cp) mode_i = nm;
                if (l >= 0 && p == 0) base[l] = hist.size();
                step(p, (l < 0) ? 0 : l);
                if (l == -2 && p == 0) ma_vb = o2_m;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0] ma;
        repeat (3) step(0, 0);
        check("reset_state", 32'(snap2()), 32'(RSTV));

        rst = 1'b0;
        r_i = 4'hA;
        step(0, 0);
        check("lat_not_early", {24'd0, o2_r}, 32'h00);
        step(0, 0);
        check("expand_A", {24'd0, o2_r}, 32'hAA);
        r_i = 4'hF;
        step(0, 0);
        step(0, 0);
        check("expand_F", {24'd0, o2_r}, 32'hFF);

        hbl_i = 1'b0; vbl_i = 1'b1; vs_i = 1'b0; hs_i = 1'b0;
        step(0, 0);
        step(0, 0);
        check("pol_blank", {29'd0, o2_hb, o2_vb, o2_de}, 32'b100);
        check("pol_colour", {8'd0, o2_r, o2_g, o2_b}, 32'h0);
        check("pol_sync", {30'd0, o2_vs, o2_hs}, 32'b10);

        hbl_i = 1'b1; vs_i = 1'b1; r_i = 4'h0; ce_i = 1'b0;
        repeat (5) step(0, 0);
        ce_i = 1'b1; hs_i = 1'b1; r_i = 4'h5;
        step(0, 0);
        ce_i = 1'b0; hs_i = 1'b0; r_i = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step(0, 0);
            check($sformatf("align2_k%0d", k), {29'd0, o2_ce, o2_hs, |o2_r},
                  (k == 2) ? 32'd7 : 32'd0);
            check($sformatf("align5_k%0d", k), {29'd0, o5_ce, o5_hs, |o5_r},
                  (k == 5) ? 32'd7 : 32'd0);
        end

        r_i = 4'h9;
        repeat (6) step(0, 0);
        check("pre_async", {24'd0, o2_r}, 32'h99);
        rst = 1'b1;
        #1;
        check("async_rst2", 32'(snap2()), 32'(RSTV));
        check("async_rst5", 32'(snap5()), 32'(RSTV));
        step(0, 0);
        step(0, 0);
        rst = 1'b0;
        step(0, 0);
        step(0, 0);
        check("post_rst", {24'd0, o2_r}, 32'h99);

        frame(4, 1'b0, 1, 100, 2'd1, ma);
        check("defer_hold", {30'd0, o2_m}, 32'd0);
        frame(2, 1'b0, 0, 50, 2'd2, ma);
        check("defer_apply", {30'd0, ma}, 32'd1);
        check("bar_px0", {8'd0, got2[base[0]]}, 32'h000000);
        check("bar_px32", {8'd0, got2[base[0] + 32]}, 32'h0000FF);
        check("bar_px224", {8'd0, got2[base[0] + 224]}, 32'hFFFFFF);

        frame(18, 1'b0, 5, 3, 2'd3, ma);
        check("grid_mode", {30'd0, ma}, 32'd2);
        check("grid_l16", {8'd0, got2[base[16] + 5]}, 32'hFFFFFF);
        check("grid_l17", {8'd0, got2[base[17] + 5]}, 32'h000000);

        dbg_i = 24'h123456; sc_en = 1'b1; sc_lvl = 2'd2;
        frame(2, 1'b0, 0, 0, 2'd0, ma);
        check("solid_even", {8'd0, got2[base[0] + 9]}, 32'h123456);
        check("solid_odd25", {8'd0, got2[base[1] + 9]}, 32'h040D15);

        sc_lvl = 2'd1;
        frame(2, 1'b1, -5, 0, 2'd0, ma);
        check("scan_even", {8'd0, got2[base[0] + 10]}, 32'hFFFFFF);
        check("scan_odd50", {8'd0, got2[base[1] + 10]}, 32'h7F7F7F);
        sc_lvl = 2'd0;
        frame(2, 1'b1, -5, 0, 2'd0, ma);
        check("scan_odd75", {8'd0, got2[base[1] + 10]}, 32'hC0C0C0);
        sc_lvl = 2'd3;
        frame(2, 1'b1, -5, 0, 2'd0, ma);
        check("scan_black", {8'd0, got2[base[1] + 10]}, 32'h000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
